// File: rtl/reg_wb_queue.sv
// Writeback FIFO in front of the register file write port, draining one entry
// per cycle, with youngest-match forwarding of pending writes to two read ports.
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wb_hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_reg_1,
    output logic              fwd_hit_1,
    output logic [DATA_W-1:0] fwd_data_1,
    input  logic [ADDR_W-1:0] rd_reg_2,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    assign in_ready = (count_q < FULL_C);
    assign push     = in_valid & in_ready & (in_reg != '0);
    assign pop      = (count_q != '0) & ~wb_hold;
    assign wr_en    = pop;
    assign wr_reg   = reg_q[head_q];
    assign wr_data  = data_q[head_q];
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[tail_q]  <= in_reg;
            data_q[tail_q] <= in_data;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_hit_1  = 1'b0;
        fwd_data_1 = '0;
        fwd_hit_2  = 1'b0;
        fwd_data_2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((rd_reg_1 != '0) && (reg_q[idx] == rd_reg_1)) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = data_q[idx];
                end
                if ((rd_reg_2 != '0) && (reg_q[idx] == rd_reg_2)) begin
                    fwd_hit_2  = 1'b1;
                    fwd_data_2 = data_q[idx];
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == FULL_C)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (count_q == '0)));

endmodule
